pipe_mmio_bank: RTL and testbench

//  Parametrised memory-mapped I/O bank for the MEM stage of the pipelined CPU.

---
 rtl/pipe_mmio_bank.sv | 94 +++++++++
 tb/tb_pipe_mmio_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_mmio_bank.sv
// rtl/pipe_mmio_bank.sv - MEM-stage I/O bank: output regs, synchronised inputs, change flags/irq, tick timer
module pipe_mmio_bank #(
  parameter int DATA_W  = 32,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 5,
  parameter int IN_W    = 6
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      sel,
  input  logic                      we,
  input  logic [4:0]                addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  input  logic [NUM_IN*IN_W-1:0]    in_ports,
  output logic [NUM_OUT*DATA_W-1:0] out_ports,
  output logic                      irq
);

  localparam logic [4:0] ADDR_CHG    = 5'h10;
  localparam logic [4:0] ADDR_IRQ_EN = 5'h11;
  localparam logic [4:0] ADDR_TICK   = 5'h12;

  logic [NUM_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [NUM_IN-1:0][IN_W-1:0]    s1_q, s2_q, s3_q;
  logic [NUM_IN-1:0]              chg_q, chg_d, chg_set;
  logic [NUM_IN-1:0]              irq_en_q, irq_en_d;
  logic [DATA_W-1:0]              tick_q, tick_d;
  logic                           wr;

  assign wr        = sel & we;
  assign out_ports = out_q;
  assign irq       = |(chg_q & irq_en_q);

  // s3 only exists to detect edges on the already-synchronised s2 value
  always_comb begin
    chg_set = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      chg_set[i] = |(s2_q[i] ^ s3_q[i]);
    end
  end

  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    tick_d   = tick_q + DATA_W'(1);
    chg_d    = chg_q | chg_set;
    if (wr) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (addr == 5'(i)) out_d[i] = wdata;
      end
      // a new change detected this cycle beats the clear
      if (addr == ADDR_CHG)    chg_d    = (chg_q & ~wdata[NUM_IN-1:0]) | chg_set;
      if (addr == ADDR_IRQ_EN) irq_en_d = wdata[NUM_IN-1:0];
      if (addr == ADDR_TICK)   tick_d   = wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      chg_q    <= '0;
      irq_en_q <= '0;
      tick_q   <= '0;
    end else begin
      out_q    <= out_d;
      s1_q     <= in_ports;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      chg_q    <= chg_d;
      irq_en_q <= irq_en_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (addr == 5'(i)) rdata = out_q[i];
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (addr == 5'(8 + i)) rdata = DATA_W'(s2_q[i]);
      end
      if (addr == ADDR_CHG)    rdata = DATA_W'(chg_q);
      if (addr == ADDR_IRQ_EN) rdata = DATA_W'(irq_en_q);
      if (addr == ADDR_TICK)   rdata = tick_q;
    end
  end

endmodule

// File: tb/tb_pipe_mmio_bank.sv
// tb/tb_pipe_mmio_bank.sv - directed self-checking bench for pipe_mmio_bank
module tb_pipe_mmio_bank;

  logic         clock;
  logic         resetn;
  logic         sel;
  logic         we;
  logic [4:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic [11:0]  in_ports;
  logic [159:0] out_ports;
  logic         irq;

  int checks;
  int errors;
  logic [31:0] rv;

  pipe_mmio_bank dut (
    .clock    (clock),
    .resetn   (resetn),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .in_ports (in_ports),
    .out_ports(out_ports),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    edge1();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    in_ports = {6'h05, 6'h03};

    repeat (2) edge1();
    check("rst_out_ports", out_ports, 160'h0);
    check("rst_irq", {159'h0, irq}, 160'h0);
    rd(5'h12, rv);
    check("rst_tick", {128'h0, rv}, 160'h0);

    resetn = 1'b1;
    sel = 1'b1; we = 1'b0; addr = 5'h10;
    edge1();
    check("chg_edge1", {128'h0, rdata}, 160'h0);
    edge1();
    check("chg_edge2", {128'h0, rdata}, 160'h0);
    edge1();
    check("chg_edge3", {128'h0, rdata}, 160'h3);
    sel = 1'b0;
    wr(5'h10, 32'h3);
    rd(5'h10, rv);
    check("chg_w1c_all", {128'h0, rv}, 160'h0);

    wr(5'h01, 32'h12345678);
    check("out1_port", out_ports, {64'h0, 32'h0, 32'h12345678, 32'h0});
    rd(5'h01, rv);
    check("out1_read", {128'h0, rv}, {128'h0, 32'h12345678});
    wr(5'h07, 32'hDEADBEEF);
    rd(5'h07, rv);
    check("out7_read", {128'h0, rv}, 160'h0);
    check("out7_noeffect", out_ports, {64'h0, 32'h0, 32'h12345678, 32'h0});
    wr(5'h08, 32'hFFFFFFFF);
    rd(5'h08, rv);
    check("in0_ro", {128'h0, rv}, 160'h3);
    rd(5'h1F, rv);
    check("unmapped_read", {128'h0, rv}, 160'h0);

    in_ports[11:6] = 6'h00;
    repeat (4) edge1();
    wr(5'h10, 32'h3);
    rd(5'h09, rv);
    check("in1_zero", {128'h0, rv}, 160'h0);
    in_ports[11:6] = 6'h2A;
    edge1();
    rd(5'h09, rv);
    check("in1_after1", {128'h0, rv}, 160'h0);
    edge1();
    rd(5'h09, rv);
    check("in1_after2", {128'h0, rv}, 160'h2A);
    rd(5'h10, rv);
    check("chg1_after2", {128'h0, rv}, 160'h0);
    edge1();
    rd(5'h10, rv);
    check("chg1_after3", {128'h0, rv}, 160'h2);
    check("irq_masked", {159'h0, irq}, 160'h0);
    wr(5'h11, 32'hFFFFFFF2);
    rd(5'h11, rv);
    check("irq_en_read", {128'h0, rv}, 160'h2);
    check("irq_on", {159'h0, irq}, 160'h1);
    wr(5'h10, 32'h2);
    rd(5'h10, rv);
    check("chg1_cleared", {128'h0, rv}, 160'h0);
    check("irq_off", {159'h0, irq}, 160'h0);

    in_ports[5:0] = 6'h3C;
    edge1();
    edge1();
    wr(5'h10, 32'h1);
    rd(5'h10, rv);
    check("collision_set_wins", {128'h0, rv}, 160'h1);
    wr(5'h10, 32'h1);
    rd(5'h10, rv);
    check("collision_later_clear", {128'h0, rv}, 160'h0);

    wr(5'h12, 32'hFFFFFFFE);
    rd(5'h12, rv);
    check("tick_load", {128'h0, rv}, {128'h0, 32'hFFFFFFFE});
    edge1();
    rd(5'h12, rv);
    check("tick_max", {128'h0, rv}, {128'h0, 32'hFFFFFFFF});
    edge1();
    rd(5'h12, rv);
    check("tick_wrap", {128'h0, rv}, 160'h0);
    repeat (5) edge1();
    rd(5'h12, rv);
    check("tick_count", {128'h0, rv}, 160'h5);

    wr(5'h11, 32'h3);
    in_ports[5:0] = 6'h01;
    repeat (3) edge1();
    check("irq_pre_reset", {159'h0, irq}, 160'h1);
    wr(5'h00, 32'hA5A5A5A5);
    wr(5'h02, 32'h0BADF00D);
    check("out_pre_reset", out_ports, {64'h0, 32'h0BADF00D, 32'h12345678, 32'hA5A5A5A5});
    sel = 1'b1; we = 1'b1; addr = 5'h03; wdata = 32'hCAFEF00D;
    #2;
    resetn = 1'b0;
    #1;
    check("async_out", out_ports, 160'h0);
    check("async_irq", {159'h0, irq}, 160'h0);
    we = 1'b0; addr = 5'h12;
    #1;
    check("async_tick", {128'h0, rdata}, 160'h0);
    sel = 1'b0;
    edge1();
    check("held_out", out_ports, 160'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
